// File: rtl/progmem_pkg.sv
// progmem_pkg: shared definitions for the program/data memory controller.
//   - bus response codes (OKAY / SLVERR)
//   - controller FSM state encoding
//   - request classification used by the controller
//   - error counter width and helper functions
package progmem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // What an IDLE-cycle request turns into.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ERR  = 2'd1,
    REQ_WR   = 2'd2,
    REQ_RD   = 2'd3
  } req_kind_e;

  // Index width of a RAM with the given number of words (at least 1 bit).
  function automatic int ram_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/progmem_ram.sv
// progmem_ram: single-port synchronous block RAM.
//   - per-byte write enables, write committed at the clock edge
//   - array read registered at the address edge, followed by RD_LAT-1
//     output pipeline registers, so rdata_o is valid RD_LAT edges after
//     the edge that sampled addr_i with rd_en_i high
//   - contents zero-filled at elaboration
// Ports:
//   clk      system clock
//   addr_i   word index (already range-checked by the controller)
//   rd_en_i  sample a read at this edge
//   wr_en_i  write at this edge
//   be_i     byte lanes to write
//   wdata_i  write data
//   rdata_o  pipelined read data
module progmem_ram
  import progmem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8192,
  parameter int RD_LAT    = 1,
  parameter     INIT_FILE = ""
) (
  input  logic                          clk,
  input  logic [ram_addr_w(DEPTH)-1:0]  addr_i,
  input  logic                          rd_en_i,
  input  logic                          wr_en_i,
  input  logic [DATA_W/8-1:0]           be_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o
);

  localparam int AW = ram_addr_w(DEPTH);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Elaboration-time contents; synthesis maps this onto the BRAM init values.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[AW'(i)] = '0;
  end

  // NOTE: the array and its read register have no reset so the tools can map
  // them onto block RAM; contents therefore survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (rd_en_i) rd_q <= mem[addr_i];
  end

  if (RD_LAT > 1) begin : g_pipe
    localparam int PIPE_W = (RD_LAT - 1) * DATA_W;
    logic [PIPE_W-1:0] pipe_q;

    // Shift register: new data enters at the low word, oldest leaves at the top.
    always_ff @(posedge clk) begin
      pipe_q <= PIPE_W'({pipe_q, rd_q});
    end

    assign rdata_o = pipe_q[PIPE_W-1 -: DATA_W];
  end else begin : g_nopipe
    assign rdata_o = rd_q;
  end

endmodule

// File: rtl/progmem_ctrl.sv
// progmem_ctrl: Avalon-MM-style slave controller in front of a block RAM.
//   - classifies each request seen in IDLE as error, write or read
//   - writes complete in 2 cycles, reads in RD_LAT+2, errors in 2
//   - SLVERR for read+write together, out-of-range address, or a write
//     while writes are disabled (ROM build or wr_lock high)
//   - saturating 16-bit count of SLVERR completions
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   ctrl_address       word address
//   ctrl_read/write    request strobes (held until waitrequest drops)
//   ctrl_byteenable    write byte lanes
//   ctrl_writedata     write data
//   ctrl_readdata      registered read data, held until the next completion
//   ctrl_response      00 OKAY / 10 SLVERR in the completion cycle, else 00
//   ctrl_waitrequest   high while a request is stalled
//   wr_lock            level, high blocks writes (sampled in IDLE)
//   err_count          saturating SLVERR completion count
module progmem_ctrl
  import progmem_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8192,
  parameter int RD_LAT    = 1,
  parameter bit WR_EN     = 1'b1,
  parameter     INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     ctrl_address,
  input  logic                  ctrl_read,
  input  logic                  ctrl_write,
  input  logic [DATA_W/8-1:0]   ctrl_byteenable,
  input  logic [DATA_W-1:0]     ctrl_writedata,
  output logic [DATA_W-1:0]     ctrl_readdata,
  output logic [1:0]            ctrl_response,
  output logic                  ctrl_waitrequest,
  input  logic                  wr_lock,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int RAM_AW = ram_addr_w(DEPTH);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]      LAT_C   = 2'(RD_LAT);

  state_e               state_q;
  logic [1:0]           cnt_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [1:0]           resp_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  req_kind_e            req_kind;
  logic                 in_range;
  logic                 wr_blocked;
  logic                 ram_rd_en;
  logic                 ram_wr_en;
  logic [DATA_W-1:0]    ram_rdata;

  // Request classification, meaningful only while the FSM is in IDLE.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    req_kind   = REQ_NONE;
    in_range   = ({1'b0, ctrl_address} < DEPTH_C);
    wr_blocked = !WR_EN || wr_lock;
    if (ctrl_read || ctrl_write) begin
      if ((ctrl_read && ctrl_write) || !in_range || (ctrl_write && wr_blocked)) begin
        req_kind = REQ_ERR;
      end else if (ctrl_write) begin
        req_kind = REQ_WR;
      end else begin
        req_kind = REQ_RD;
      end
    end
  end

  // RAM is touched only by a legal IDLE request, and never while in reset.
  assign ram_wr_en = rst_n && (state_q == IDLE) && (req_kind == REQ_WR);
  assign ram_rd_en = rst_n && (state_q == IDLE) && (req_kind == REQ_RD);

  assign err_cnt_d = sat_inc(err_cnt_q);

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is sampled inside the clocked block, so it acts at the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          resp_q <= RESP_OKAY;
          unique case (req_kind)
            REQ_ERR: begin
              state_q   <= DONE;
              resp_q    <= RESP_SLVERR;
              rdata_q   <= '0;
              err_cnt_q <= err_cnt_d;
            end
            REQ_WR: begin
              state_q <= DONE;
            end
            REQ_RD: begin
              // One RD_WAIT cycle per RAM latency cycle; the last one
              // captures the RAM output on the way into DONE.
              state_q <= RD_WAIT;
              cnt_q   <= LAT_C;
            end
            default: ;
          endcase
        end
        RD_WAIT: begin
          if (cnt_q == 2'd1) begin
            state_q <= DONE;
            cnt_q   <= '0;
            rdata_q <= ram_rdata;
            resp_q  <= RESP_OKAY;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          resp_q  <= RESP_OKAY;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  progmem_ram #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RD_LAT    (RD_LAT),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ctrl_address[RAM_AW-1:0]),
    .rd_en_i (ram_rd_en),
    .wr_en_i (ram_wr_en),
    .be_i    (ctrl_byteenable),
    .wdata_i (ctrl_writedata),
    .rdata_o (ram_rdata)
  );

  assign ctrl_waitrequest = (ctrl_read || ctrl_write) && (state_q != DONE);
  assign ctrl_readdata    = rdata_q;
  assign ctrl_response    = resp_q;
  assign err_count        = err_cnt_q;

endmodule

// File: tb/tb_progmem_ctrl.sv
// Testbench for progmem_ctrl. Three instances cover the configurations of
// interest: u0 RD_LAT=1 full depth, u1 RD_LAT=3 DEPTH=4096, u2 ROM build
// (WR_EN=0) with RD_LAT=2 and a non-power-of-two depth.
module tb_progmem_ctrl;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [12:0] addr_s [ND];
  logic        rd_s   [ND];
  logic        wr_s   [ND];
  logic [3:0]  be_s   [ND];
  logic [31:0] wd_s   [ND];
  logic        lock_s [ND];

  logic [31:0] rdata_w [ND];
  logic [1:0]  resp_w  [ND];
  logic        wait_w  [ND];
  logic [15:0] errc_w  [ND];

  always #5 clk = ~clk;

  progmem_ctrl #(.ADDR_W(13), .DATA_W(32), .DEPTH(8192), .RD_LAT(1), .WR_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .ctrl_address(addr_s[0]), .ctrl_read(rd_s[0]),
    .ctrl_write(wr_s[0]), .ctrl_byteenable(be_s[0]), .ctrl_writedata(wd_s[0]),
    .ctrl_readdata(rdata_w[0]), .ctrl_response(resp_w[0]), .ctrl_waitrequest(wait_w[0]),
    .wr_lock(lock_s[0]), .err_count(errc_w[0]));

  progmem_ctrl #(.ADDR_W(13), .DATA_W(32), .DEPTH(4096), .RD_LAT(3), .WR_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .ctrl_address(addr_s[1]), .ctrl_read(rd_s[1]),
    .ctrl_write(wr_s[1]), .ctrl_byteenable(be_s[1]), .ctrl_writedata(wd_s[1]),
    .ctrl_readdata(rdata_w[1]), .ctrl_response(resp_w[1]), .ctrl_waitrequest(wait_w[1]),
    .wr_lock(lock_s[1]), .err_count(errc_w[1]));

  progmem_ctrl #(.ADDR_W(13), .DATA_W(32), .DEPTH(1000), .RD_LAT(2), .WR_EN(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .ctrl_address(addr_s[2]), .ctrl_read(rd_s[2]),
    .ctrl_write(wr_s[2]), .ctrl_byteenable(be_s[2]), .ctrl_writedata(wd_s[2]),
    .ctrl_readdata(rdata_w[2]), .ctrl_response(resp_w[2]), .ctrl_waitrequest(wait_w[2]),
    .wr_lock(lock_s[2]), .err_count(errc_w[2]));

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int cfg_depth(input int d);
    case (d)
      0:       return 8192;
      1:       return 4096;
      default: return 1000;
    endcase
  endfunction

  function automatic int cfg_lat(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit cfg_wren(input int d);
    return d != 2;
  endfunction

  logic [31:0] mem_m [int];
  logic [31:0] last_m [ND];
  int          errc_m [ND];

  function automatic logic [31:0] mem_get(input int d, input int a);
    int key = d * 16384 + a;
    return mem_m.exists(key) ? mem_m[key] : 32'h0;
  endfunction

  // One transaction as seen from the bus: returns the response, the data
  // presented at completion, and the number of stalled cycles before it.
  function automatic void model_txn(input int d, input bit rd, input bit wr,
                                    input logic [12:0] addr, input logic [3:0] be,
                                    input logic [31:0] wd, input bit lock,
                                    output logic [1:0] resp, output logic [31:0] data,
                                    output int cyc);
    int  a = int'(addr);
    bit  err = (rd && wr) || (a >= cfg_depth(d)) || (wr && (!cfg_wren(d) || lock));
    logic [31:0] v;
    if (err) begin
      resp = 2'b10; data = 32'h0; cyc = 1;
      last_m[d] = 32'h0;
      if (errc_m[d] < 65535) errc_m[d]++;
    end else if (wr) begin
      v = mem_get(d, a);
      for (int b = 0; b < 4; b++) if (be[b]) v[b*8 +: 8] = wd[b*8 +: 8];
      mem_m[d * 16384 + a] = v;
      resp = 2'b00; data = last_m[d]; cyc = 1;
    end else begin
      data = mem_get(d, a);
      last_m[d] = data;
      resp = 2'b00; cyc = cfg_lat(d) + 1;
    end
  endfunction

  // ---------------------------------------------------------------- driving
  // Counts stalled cycles until waitrequest drops (bounded), samples the
  // completion outputs, then drops the request after the completion edge.
  task automatic wait_done(input int d, output logic [1:0] resp, output logic [31:0] data,
                           output logic [15:0] errc, output int cyc);
    bit done = 0;
    cyc = 0;
    while (!done) begin
      @(negedge clk);
      if (wait_w[d] === 1'b0) begin
        done = 1;
      end else begin
        if (cyc == 0) check($sformatf("u%0d resp before completion", d), 32'(resp_w[d]), 32'h0);
        cyc++;
        if (cyc > 16) done = 1;
      end
    end
    resp = resp_w[d]; data = rdata_w[d]; errc = errc_w[d];
    @(posedge clk); #1;
    rd_s[d] = 1'b0; wr_s[d] = 1'b0; lock_s[d] = 1'b0;
  endtask

  task automatic run_txn(input int d, input bit rd, input bit wr, input logic [12:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input bit lock,
                         output logic [1:0] resp, output logic [31:0] data,
                         output logic [15:0] errc, output int cyc);
    addr_s[d] = addr; rd_s[d] = rd; wr_s[d] = wr; be_s[d] = be; wd_s[d] = wd; lock_s[d] = lock;
    wait_done(d, resp, data, errc, cyc);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int          d;
    bit          rd;
    bit          wr;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          lock;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
    int          errc;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  g_resp, e_resp;
    logic [31:0] g_data, e_data;
    logic [15:0] g_errc;
    int          g_cyc, e_cyc;

    //            d rd wr addr      be    wd            lk resp  data          cyc errc
    vecs.push_back('{0, 1'b0, 1'b1, 13'h010, 4'hF, 32'hDEADBEEF, 1'b0, 2'b00, 32'h00000000, 1, 0});
    vecs.push_back('{0, 1'b1, 1'b0, 13'h010, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'hDEADBEEF, 2, 0});
    vecs.push_back('{0, 1'b0, 1'b1, 13'h005, 4'hF, 32'hAAAAAAAA, 1'b0, 2'b00, 32'hDEADBEEF, 1, 0});
    vecs.push_back('{0, 1'b0, 1'b1, 13'h005, 4'h5, 32'h11223344, 1'b0, 2'b00, 32'hDEADBEEF, 1, 0});
    vecs.push_back('{0, 1'b1, 1'b0, 13'h005, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'hAA22AA44, 2, 0});
    vecs.push_back('{0, 1'b0, 1'b1, 13'h007, 4'hF, 32'hCAFEF00D, 1'b0, 2'b00, 32'hAA22AA44, 1, 0});
    vecs.push_back('{0, 1'b0, 1'b1, 13'h007, 4'hF, 32'h12345678, 1'b1, 2'b10, 32'h00000000, 1, 1});
    vecs.push_back('{0, 1'b1, 1'b0, 13'h007, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'hCAFEF00D, 2, 1});
    vecs.push_back('{0, 1'b1, 1'b1, 13'h007, 4'hF, 32'h00000000, 1'b0, 2'b10, 32'h00000000, 1, 2});
    vecs.push_back('{0, 1'b1, 1'b0, 13'h007, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'hCAFEF00D, 2, 2});
    vecs.push_back('{1, 1'b0, 1'b1, 13'h0FFF, 4'hF, 32'h5A5A1234, 1'b0, 2'b00, 32'h00000000, 1, 0});
    vecs.push_back('{1, 1'b1, 1'b0, 13'h0FFF, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'h5A5A1234, 4, 0});
    vecs.push_back('{1, 1'b1, 1'b0, 13'h1000, 4'hF, 32'h00000000, 1'b0, 2'b10, 32'h00000000, 1, 1});
    vecs.push_back('{1, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'hFFFFFFFF, 1'b0, 2'b10, 32'h00000000, 1, 2});
    vecs.push_back('{1, 1'b1, 1'b0, 13'h0000, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'h00000000, 4, 2});
    vecs.push_back('{2, 1'b0, 1'b1, 13'h003, 4'hF, 32'h12345678, 1'b0, 2'b10, 32'h00000000, 1, 1});
    vecs.push_back('{2, 1'b0, 1'b1, 13'h003, 4'hF, 32'h12345678, 1'b1, 2'b10, 32'h00000000, 1, 2});
    vecs.push_back('{2, 1'b1, 1'b0, 13'h003, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'h00000000, 3, 2});
    vecs.push_back('{2, 1'b1, 1'b0, 13'h3E7, 4'hF, 32'h00000000, 1'b0, 2'b00, 32'h00000000, 3, 2});
    vecs.push_back('{2, 1'b1, 1'b0, 13'h3E8, 4'hF, 32'h00000000, 1'b0, 2'b10, 32'h00000000, 1, 3});

    for (int d = 0; d < ND; d++) begin
      addr_s[d] = '0; rd_s[d] = 1'b0; wr_s[d] = 1'b0; be_s[d] = '0; wd_s[d] = '0; lock_s[d] = 1'b0;
      last_m[d] = '0; errc_m[d] = 0;
    end

    // ---- reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("u%0d reset readdata", d), rdata_w[d], 32'h0);
      check($sformatf("u%0d reset response", d), 32'(resp_w[d]), 32'h0);
      check($sformatf("u%0d reset err_count", d), 32'(errc_w[d]), 32'h0);
      check($sformatf("u%0d reset waitrequest idle", d), 32'(wait_w[d]), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- directed table
    foreach (vecs[i]) begin
      model_txn(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd,
                vecs[i].lock, e_resp, e_data, e_cyc);
      run_txn(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd,
              vecs[i].lock, g_resp, g_data, g_errc, g_cyc);
      check($sformatf("vec%0d response", i), 32'(g_resp), 32'(vecs[i].resp));
      check($sformatf("vec%0d readdata", i), g_data, vecs[i].data);
      check($sformatf("vec%0d stall cycles", i), 32'(g_cyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d err_count", i), 32'(g_errc), 32'(vecs[i].errc));
    end

    // ---- held read on u0: two back-to-back transactions, one per RD_LAT+2 cycles
    addr_s[0] = 13'h010; rd_s[0] = 1'b1; wr_s[0] = 1'b0;
    model_txn(0, 1'b1, 1'b0, 13'h010, 4'h0, 32'h0, 1'b0, e_resp, e_data, e_cyc);
    model_txn(0, 1'b1, 1'b0, 13'h010, 4'h0, 32'h0, 1'b0, e_resp, e_data, e_cyc);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("held read cycle %0d waitrequest", k), 32'(wait_w[0]), 32'((k % 3) != 2));
      if ((k % 3) == 2) check($sformatf("held read cycle %0d data", k), rdata_w[0], e_data);
      @(posedge clk); #1;
    end
    rd_s[0] = 1'b0;

    // ---- wr_lock raised in cycle 1 of a write does not affect it
    addr_s[0] = 13'h014; wd_s[0] = 32'h0BADF00D; be_s[0] = 4'hF; wr_s[0] = 1'b1; lock_s[0] = 1'b0;
    model_txn(0, 1'b0, 1'b1, 13'h014, 4'hF, 32'h0BADF00D, 1'b0, e_resp, e_data, e_cyc);
    @(negedge clk);
    check("lock change cycle0 waitrequest", 32'(wait_w[0]), 32'h1);
    @(posedge clk); #1;
    lock_s[0] = 1'b1;
    @(negedge clk);
    check("lock change completion waitrequest", 32'(wait_w[0]), 32'h0);
    check("lock change response", 32'(resp_w[0]), 32'(e_resp));
    @(posedge clk); #1;
    wr_s[0] = 1'b0; lock_s[0] = 1'b0;
    model_txn(0, 1'b1, 1'b0, 13'h014, 4'hF, 32'h0, 1'b0, e_resp, e_data, e_cyc);
    run_txn(0, 1'b1, 1'b0, 13'h014, 4'hF, 32'h0, 1'b0, g_resp, g_data, g_errc, g_cyc);
    check("lock change readback", g_data, e_data);

    // ---- reset in cycle 1 of an RD_LAT=3 read, request held throughout
    addr_s[1] = 13'h0FFF; rd_s[1] = 1'b1; wr_s[1] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("reset cycle %0d waitrequest", k), 32'(wait_w[1]), 32'h1);
      check($sformatf("reset cycle %0d response", k), 32'(resp_w[1]), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("u%0d err_count in reset", d), 32'(errc_w[d]), 32'h0);
      check($sformatf("u%0d readdata in reset", d), rdata_w[d], 32'h0);
      last_m[d] = '0; errc_m[d] = 0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_txn(1, 1'b1, 1'b0, 13'h0FFF, 4'h0, 32'h0, 1'b0, e_resp, e_data, e_cyc);
    wait_done(1, g_resp, g_data, g_errc, g_cyc);
    check("read after reset stall cycles", 32'(g_cyc), 32'(e_cyc));
    check("read after reset data", g_data, e_data);
    check("read after reset response", 32'(g_resp), 32'(e_resp));

    // ---- err_count saturation on u0
    @(negedge clk);
    force u0.err_cnt_q = 16'hFFFF;
    #1;
    release u0.err_cnt_q;
    errc_m[0] = 65535;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      model_txn(0, 1'b1, 1'b1, 13'h000, 4'hF, 32'h0, 1'b0, e_resp, e_data, e_cyc);
      run_txn(0, 1'b1, 1'b1, 13'h000, 4'hF, 32'h0, 1'b0, g_resp, g_data, g_errc, g_cyc);
      check($sformatf("saturation err %0d response", k), 32'(g_resp), 32'(e_resp));
      check($sformatf("saturation err %0d err_count", k), 32'(g_errc), 32'(errc_m[0]));
    end

    // ---- randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int          d = $urandom_range(0, ND - 1);
      int          op = $urandom_range(0, 99);
      int          a;
      bit          rd, wr, lk;
      logic [3:0]  be;
      logic [31:0] wd;
      rd = (op < 45) || (op >= 92);
      wr = (op >= 45);
      if ($urandom_range(0, 3) == 0) begin
        a = cfg_depth(d) - 2 + $urandom_range(0, 3);
        if (a > 8191) a = 8191;
      end else begin
        a = $urandom_range(0, 15);
      end
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      lk = ($urandom_range(0, 4) == 0);
      model_txn(d, rd, wr, 13'(a), be, wd, lk, e_resp, e_data, e_cyc);
      run_txn(d, rd, wr, 13'(a), be, wd, lk, g_resp, g_data, g_errc, g_cyc);
      check($sformatf("rnd%0d u%0d response", i, d), 32'(g_resp), 32'(e_resp));
      check($sformatf("rnd%0d u%0d readdata", i, d), g_data, e_data);
      check($sformatf("rnd%0d u%0d stall cycles", i, d), 32'(g_cyc), 32'(e_cyc));
      check($sformatf("rnd%0d u%0d err_count", i, d), 32'(g_errc), 32'(errc_m[d]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
